// File: rtl/servo_error_stage.sv
// servo_error_stage: two-stage registered error block for the servo position loop.
// Stage 1 forms the saturated error e[k] = ref - yk on each sample strobe.
// Stage 2 publishes e[k], e[k-1], the saturated first difference and
// (optionally) a clamped running sum, with valid two cycles after the strobe.
// Optional feature macro: SERVO_ERROR_INTEGRAL_EN builds the integral
// accumulator; without it sum_e is tied to zero.
// The setpoint port is named ref_val because "ref" is a reserved word in
// SystemVerilog.
module servo_error_stage #(
    parameter int N    = 19,
    parameter int ILIM = 131071
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                sample_en,
    input  logic signed [N-1:0] ref_val,
    input  logic signed [N-1:0] yk,
    output logic signed [N-1:0] ek,
    output logic signed [N-1:0] ek_1,
    output logic signed [N-1:0] dek,
    output logic signed [N-1:0] sum_e,
    output logic                valid
);

    // Reject an unusable clamp magnitude at elaboration time.
    if (ILIM <= 0 || ILIM > 2**(N-1)-1) begin : g_ilim_bad
        $error("servo_error_stage: ILIM outside 1 .. 2^(N-1)-1");
    end

    localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    // Saturate an N+1 bit result back into N bits.
    function automatic logic signed [N-1:0] sat(input logic signed [N:0] x);
        if (x[N] != x[N-1])
            return x[N] ? SMIN : SMAX;
        return x[N-1:0];
    endfunction

    typedef enum logic {EMPTY, PRIMED} state_t;

    state_t              state, state_nxt;
    logic                v_s1;
    logic signed [N-1:0] e_s1;
    logic signed [N:0]   diff_s1;
    logic signed [N:0]   diff_s2;

    // Full-width difference so the subtraction itself never wraps.
    always_comb begin
        diff_s1 = {ref_val[N-1], ref_val} - {yk[N-1], yk};
        diff_s2 = {e_s1[N-1], e_s1} - {ek[N-1], ek};
    end

    // Stage 1: capture and saturate the loop error on the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_s1 <= 1'b0;
            e_s1 <= '0;
        end else if (clear) begin
            v_s1 <= 1'b0;
            e_s1 <= '0;
        end else begin
            v_s1 <= sample_en;
            if (sample_en)
                e_s1 <= sat(diff_s1);
        end
    end

    // Priming state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Priming next state: first stage-2 update primes, clear empties.
    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = EMPTY;
        else if (v_s1)
            state_nxt = PRIMED;
    end

    // Stage 2: publish e[k], e[k-1] and the first difference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            ek    <= '0;
            ek_1  <= '0;
            dek   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ek    <= '0;
            ek_1  <= '0;
            dek   <= '0;
        end else begin
            valid <= v_s1;
            if (v_s1) begin
                ek <= e_s1;
                if (state == PRIMED) begin
                    ek_1 <= ek;
                    dek  <= sat(diff_s2);
                end else begin
                    // No history yet: previous sample mirrors the current one.
                    ek_1 <= e_s1;
                    dek  <= '0;
                end
            end
        end
    end

`ifdef SERVO_ERROR_INTEGRAL_EN
    localparam logic signed [N:0] I_HI = ILIM[N:0];
    localparam logic signed [N:0] I_LO = -I_HI;

    logic signed [N-1:0] sum_q;
    logic signed [N:0]   sum_ext;

    // Sum stays within +/-ILIM, so N+1 bits can never overflow here.
    always_comb begin
        sum_ext = {sum_q[N-1], sum_q} + {e_s1[N-1], e_s1};
    end

    // Clamped integral, updated alongside the stage-2 outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sum_q <= '0;
        else if (clear)
            sum_q <= '0;
        else if (v_s1) begin
            if (sum_ext > I_HI)
                sum_q <= I_HI[N-1:0];
            else if (sum_ext < I_LO)
                sum_q <= I_LO[N-1:0];
            else
                sum_q <= sum_ext[N-1:0];
        end
    end

    assign sum_e = sum_q;
`else
    assign sum_e = '0;
`endif

endmodule

// File: tb/tb_servo_error_stage.sv
// Directed scoreboard bench for servo_error_stage (N=19, ILIM=100000).
// Expected outputs are queued when a sample is driven and compared when
// valid appears; a valid with nothing queued is an error.
module tb_servo_error_stage;
    localparam int N    = 19;
    localparam int ILIM = 100000;
    localparam int SMAX = 262143;
    localparam int SMIN = -262144;

    typedef struct {
        logic signed [N-1:0] ek;
        logic signed [N-1:0] ek_1;
        logic signed [N-1:0] dek;
        logic signed [N-1:0] sum_e;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                clear = 1'b0;
    logic                sample_en = 1'b0;
    logic signed [N-1:0] ref_val = '0;
    logic signed [N-1:0] yk = '0;
    logic signed [N-1:0] ek, ek_1, dek, sum_e;
    logic                valid;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // model state
    int   m_ek = 0;
    int   m_sum = 0;
    bit   m_primed = 1'b0;

    servo_error_stage #(.N(N), .ILIM(ILIM)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .sample_en(sample_en),
        .ref_val(ref_val), .yk(yk), .ek(ek), .ek_1(ek_1), .dek(dek),
        .sum_e(sum_e), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic int satn(input int x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    function automatic void model_reset();
        m_ek = 0;
        m_sum = 0;
        m_primed = 1'b0;
    endfunction

    // Compute expected stage-2 result for one sample and queue it.
    function automatic void push_exp(input int r, input int y);
        exp_t x;
        int   e;
        e = satn(r - y);
        x.ek   = e[N-1:0];
        x.ek_1 = m_primed ? m_ek[N-1:0] : e[N-1:0];
        if (m_primed) begin
            int d;
            d = satn(e - m_ek);
            x.dek = d[N-1:0];
        end else
            x.dek = '0;
`ifdef SERVO_ERROR_INTEGRAL_EN
        m_sum = m_sum + e;
        if (m_sum > ILIM) m_sum = ILIM;
        if (m_sum < -ILIM) m_sum = -ILIM;
`else
        m_sum = 0;
`endif
        x.sum_e = m_sum[N-1:0];
        m_ek = e;
        m_primed = 1'b1;
        q.push_back(x);
    endfunction

    // Scoreboard: compare every valid against the oldest queued expectation.
    always @(negedge clk) begin
        if (valid) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid: got valid=1 with ek=%0d, required no valid", ek);
            end
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                assert (ek === x.ek) else begin
                    errors++; $error("FAIL ek: got %0d required %0d", ek, x.ek);
                end
                checks++;
                assert (ek_1 === x.ek_1) else begin
                    errors++; $error("FAIL ek_1: got %0d required %0d", ek_1, x.ek_1);
                end
                checks++;
                assert (dek === x.dek) else begin
                    errors++; $error("FAIL dek: got %0d required %0d", dek, x.dek);
                end
                checks++;
                assert (sum_e === x.sum_e) else begin
                    errors++; $error("FAIL sum_e: got %0d required %0d", sum_e, x.sum_e);
                end
            end
        end
    end

    // Drive one strobe for one cycle; caller is just after a rising edge.
    task automatic sample(input int r, input int y);
        sample_en = 1'b1;
        ref_val = r[N-1:0];
        yk = y[N-1:0];
        push_exp(r, y);
        @(posedge clk); #1;
        sample_en = 1'b0;
        ref_val = N'($urandom);
        yk = N'($urandom);
    endtask

    // Wait (bounded) for every queued expectation to be consumed.
    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(negedge clk);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: got %0d pending results, required 0", tag, q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        checks++;
        assert ({valid, ek, ek_1, dek, sum_e} === '0) else begin
            errors++;
            $error("FAIL %s: got valid=%0b ek=%0d ek_1=%0d dek=%0d sum_e=%0d, required all 0",
                   tag, valid, ek, ek_1, dek, sum_e);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        q.delete();
    endtask

    initial begin
        // 1. reset with random inputs
        sample_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ref_val = N'($urandom);
            yk = N'($urandom);
            clear = 1'($urandom);
            check_zero("reset_hold");
        end
        sample_en = 1'b0;
        clear = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_zero("after_release");
        check_zero("after_release2");
        @(posedge clk); #1;

        // 2. first sample, then hold check
        sample(1000, 400);
        drain("first");
        @(negedge clk);
        checks++;
        assert (valid === 1'b0 && ek === 19'sd600) else begin
            errors++;
            $error("FAIL hold: got valid=%0b ek=%0d, required valid=0 ek=600", valid, ek);
        end
        @(posedge clk); #1;

        // 3. second sample, then back-to-back pair
        sample(1000, 900);
        drain("second");
        sample(1000, 400);
        sample(1000, 900);
        drain("back_to_back");

        // 4. saturation
        sample(200000, -200000);
        sample(-200000, 200000);
        drain("saturation");

        // 5. integral clamp from a clean history
        do_clear();
        for (int i = 0; i < 4; i++)
            sample(40000, 0);
        sample(-150000, 0);
        sample(-150000, 0);
        drain("integral");

        // 6a. clear together with a strobe: sample dropped
        sample_en = 1'b1;
        clear = 1'b1;
        ref_val = 19'sd77;
        yk = 19'sd1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        clear = 1'b0;
        model_reset();
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_zero("clear_with_sample");
        @(posedge clk); #1;

        // 6b. fresh history after clear
        sample(5, 2);
        drain("after_clear");

        // 6c. reset pulse while the sample sits in stage 1
        sample_en = 1'b1;
        ref_val = 19'sd50;
        yk = 19'sd10;
        @(posedge clk); #1;
        sample_en = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_in_flight");

        // history restarted: next sample must be unprimed
        @(posedge clk); #1;
        sample(-30, 12);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
